clkctl: RTL and testbench

CLKCTL -- requirements
Module: clkctl

---
 rtl/clkctl_pkg.sv | 14 +
 rtl/clkctl_step_edge.sv | 30 +++
 rtl/clkctl.sv | 100 ++++++++++
 tb/tb_clkctl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkctl_pkg.sv
// rtl/clkctl_pkg.sv - shared types and limits for the clkctl phase clock controller
package clkctl_pkg;

   localparam int PHASES_MAX = 8;
   localparam int PHASE_W    = $clog2(PHASES_MAX);

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } state_t;

endpackage

// File: rtl/clkctl_step_edge.sv
// rtl/clkctl_step_edge.sv - step rising-edge detector; CLKCTL_STEP_SYNC_EN adds a 2-flop synchronizer
module clkctl_step_edge (
   input  logic sysclk,
   input  logic reset,
   input  logic step,
   output logic evt
);

`ifdef CLKCTL_STEP_SYNC_EN
   // sync[1:0] is the synchronizer, sync[2] holds the previous synchronized level
   logic [2:0] sync;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) sync <= '0;
      else       sync <= {sync[1:0], step};
   end

   assign evt = sync[1] & ~sync[2];
`else
   logic step_d;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) step_d <= 1'b0;
      else       step_d <= step;
   end

   assign evt = step & ~step_d;
`endif

endmodule

// File: rtl/clkctl.sv
// rtl/clkctl.sv - multi-phase clock enable generator with run/step/halt control
// Step input handling selected by CLKCTL_STEP_SYNC_EN (see clkctl_step_edge).
module clkctl
   import clkctl_pkg::*;
#(
   parameter int PHASES = 2,
   parameter int DIV_W  = 8
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic [DIV_W-1:0]  div,
   input  logic              run,
   input  logic              step,
   input  logic              halt,
   output logic [PHASES-1:0] clken,
   output logic              slowclk,
   output logic              active,
   output logic              halted
);

   state_t             state, state_nx;
   logic [DIV_W-1:0]   sub;
   logic [DIV_W-1:0]   eff_div;
   logic [PHASE_W-1:0] phase;
   logic               halt_pend;
   logic               step_evt;
   logic               running;
   logic               sub_last;
   logic               period_end;

   clkctl_step_edge u_step_edge (
      .sysclk (sysclk),
      .reset  (reset),
      .step   (step),
      .evt    (step_evt)
   );

   assign running    = (state == RUN) || (state == STEP);
   assign sub_last   = (sub == eff_div - 1'b1);
   assign period_end = running && sub_last && (phase == PHASE_W'(PHASES - 1));

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state     <= STOP;
         sub       <= '0;
         phase     <= '0;
         halt_pend <= 1'b0;
         eff_div   <= DIV_W'(1);
      end else begin
         state <= state_nx;
         if (halt)
            halt_pend <= 1'b1;
         // divisor only changes at a period boundary so a period is never stretched
         if ((state == STOP) || period_end)
            eff_div <= (div == '0) ? DIV_W'(1) : div;
         if (!running || period_end) begin
            sub   <= '0;
            phase <= '0;
         end else if (sub_last) begin
            sub   <= '0;
            phase <= phase + 1'b1;
         end else begin
            sub <= sub + 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         STOP: begin
            if (run)           state_nx = RUN;
            else if (step_evt) state_nx = STEP;
         end
         RUN: begin
            if (period_end) begin
               if (halt_pend || halt) state_nx = HALT;
               else if (!run)         state_nx = STOP;
            end
         end
         STEP: begin
            if (period_end)
               state_nx = (halt_pend || halt) ? HALT : STOP;
         end
         HALT:    state_nx = HALT;
         default: state_nx = STOP;
      endcase
   end

   always_comb begin
      clken = '0;
      for (int p = 0; p < PHASES; p++)
         clken[p] = running && (sub == '0) && (phase == PHASE_W'(p));
   end

   assign slowclk = running && (phase < PHASE_W'(PHASES / 2));
   assign active  = running;
   assign halted  = (state == HALT);

endmodule

// File: tb/tb_clkctl.sv
// tb/tb_clkctl.sv - self-checking bench for clkctl; PHASES=2 and PHASES=4 instances share stimulus
module tb_clkctl;

`ifdef CLKCTL_STEP_SYNC_EN
   localparam int STEP_LAT = 3;
`else
   localparam int STEP_LAT = 1;
`endif

   logic       sysclk = 1'b0;
   logic       reset;
   logic       run  = 1'b0;
   logic       step = 1'b0;
   logic       halt = 1'b0;
   logic [7:0] div  = 8'd1;

   logic [1:0] ce2;
   logic [3:0] ce4;
   logic       sc2, sc4, ac2, ac4, hd2, hd4;

   int ncmp  = 0;
   int nfail = 0;
   int first;

   // reference model: mode 0=stopped 1=running 2=stepping 3=halted, t = cycle within period
   int  mode[2], t[2], eff[2], pcnt[2];
   bit  hp[2];
   bit  h1, h2, h3;

   always #5 sysclk = ~sysclk;

   clkctl #(.PHASES(2), .DIV_W(8)) u_p2 (
      .sysclk(sysclk), .reset(reset), .div(div), .run(run), .step(step), .halt(halt),
      .clken(ce2), .slowclk(sc2), .active(ac2), .halted(hd2)
   );

   clkctl #(.PHASES(4), .DIV_W(8)) u_p4 (
      .sysclk(sysclk), .reset(reset), .div(div), .run(run), .step(step), .halt(halt),
      .clken(ce4), .slowclk(sc4), .active(ac4), .halted(hd4)
   );

   function automatic int ph(int i);
      return (i == 0) ? 2 : 4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mode[i] = 0;
         t[i]    = 0;
         eff[i]  = 1;
         hp[i]   = 1'b0;
      end
      h1 = 1'b0;
      h2 = 1'b0;
      h3 = 1'b0;
   endtask

   task automatic model_edge();
      bit ev;
`ifdef CLKCTL_STEP_SYNC_EN
      ev = h2 && !h3;
`else
      ev = step && !h1;
`endif
      for (int i = 0; i < 2; i++) begin
         int per;
         bit act;
         bit fin;
         int nm;
         per = eff[i] * ph(i);
         act = (mode[i] == 1) || (mode[i] == 2);
         fin = act && (t[i] == per - 1);
         nm  = mode[i];
         case (mode[i])
            0: nm = run ? 1 : (ev ? 2 : 0);
            1: if (fin) nm = (hp[i] || halt) ? 3 : (!run ? 0 : 1);
            2: if (fin) nm = (hp[i] || halt) ? 3 : 0;
            default: nm = mode[i];
         endcase
         if (mode[i] == 0 || fin)
            eff[i] = (div == 8'd0) ? 1 : int'(div);
         t[i] = (act && !fin) ? t[i] + 1 : 0;
         if (halt) hp[i] = 1'b1;
         mode[i] = nm;
      end
      h3 = h2;
      h2 = h1;
      h1 = step;
   endtask

   function automatic logic [10:0] expv(int i);
      logic [7:0] ce;
      bit act;
      int slot;
      ce   = '0;
      act  = (mode[i] == 1) || (mode[i] == 2);
      slot = t[i] / eff[i];
      if (act && (t[i] % eff[i] == 0)) ce[slot] = 1'b1;
      return {ce, act && (slot < ph(i) / 2), act, mode[i] == 3};
   endfunction

   task automatic check(string tag);
      logic [10:0] o[2];
      o[0] = {6'b0, ce2, sc2, ac2, hd2};
      o[1] = {4'b0, ce4, sc4, ac4, hd4};
      for (int i = 0; i < 2; i++) begin
         ncmp++;
         assert (o[i] === expv(i)) else begin
            nfail++;
            $error("FAIL %s phases=%0d obs={clken,slow,act,halt}=%h exp=%h", tag, ph(i), o[i], expv(i));
         end
      end
   endtask

   task automatic tick(string tag);
      @(posedge sysclk);
      if (reset) model_reset();
      else       model_edge();
      #1;
      pcnt[0] += $countones(ce2);
      pcnt[1] += $countones(ce4);
      check(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check("reset_async");
      tick("reset_hold");
      reset = 1'b0;
   endtask

   task automatic expect_int(string tag, int obs, int exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      #2;
      do_reset();

      // free run, div=4: 8- and 16-cycle periods, then run drop completes the period
      div = 8'd4;
      run = 1'b1;
      repeat (40) tick("run_div4");
      run = 1'b0;
      repeat (20) tick("run_stop");

      // single step event, div=3
      div = 8'd3;
      pcnt = '{0, 0};
      step = 1'b1;
      tick("step_pulse");
      step = 1'b0;
      repeat (25) tick("step_run");
      expect_int("step_pulses_p2", pcnt[0], 2);
      expect_int("step_pulses_p4", pcnt[1], 4);
      expect_int("step_done_active", int'(ac4), 0);

      // step held high for 5 cycles: one period, start latency depends on sync build
      div = 8'd2;
      pcnt = '{0, 0};
      first = -1;
      for (int n = 1; n <= 20; n++) begin
         step = (n <= 5);
         tick("step_hold");
         if (first < 0 && ce4[0]) first = n;
      end
      expect_int("step_latency", first, STEP_LAT);
      expect_int("hold_pulses_p2", pcnt[0], 2);
      expect_int("hold_pulses_p4", pcnt[1], 4);

      // div=0 behaves as div=1
      div = 8'd0;
      run = 1'b1;
      pcnt = '{0, 0};
      repeat (12) tick("div0");
      expect_int("div0_pulses_p4", pcnt[1], 12);
      run = 1'b0;
      repeat (6) tick("div0_stop");

      // divisor change mid-period only applies from the next period
      div = 8'd4;
      run = 1'b1;
      repeat (3) tick("divchg_a");
      div = 8'd2;
      repeat (30) tick("divchg_b");
      run = 1'b0;
      repeat (20) tick("divchg_stop");

      // randomized run/step/div traffic with occasional resets
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         step = ($urandom_range(0, 3) == 0);
         div  = 8'($urandom_range(0, 5));
         if ($urandom_range(0, 59) == 0) do_reset();
         else tick("random");
      end

      // reset mid-period, then restart with run held high
      run  = 1'b0;
      step = 1'b0;
      do_reset();
      div = 8'd3;
      run = 1'b1;
      repeat (5) tick("pre_reset_run");
      do_reset();
      tick("post_reset");
      expect_int("post_reset_clken0", int'(ce4[0]), 1);

      // halt pulse while running: period completes, then terminal HALT
      div = 8'd2;
      repeat (4) tick("halt_pre");
      halt = 1'b1;
      tick("halt_pulse");
      halt = 1'b0;
      repeat (20) tick("halt_finish");
      for (int n = 0; n < 20; n++) begin
         run  = $urandom_range(0, 1);
         step = $urandom_range(0, 1);
         div  = 8'($urandom_range(0, 5));
         tick("halt_ignore");
      end
      expect_int("halted_p2", int'(hd2), 1);
      expect_int("halted_p4", int'(hd4), 1);
      run  = 1'b0;
      step = 1'b0;
      do_reset();
      expect_int("reset_clears_halt", int'(hd4), 0);
      run = 1'b1;
      repeat (10) tick("rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
